// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares the single external SRAM port between the encoder masters
//   (UART loader, colour-space/downsample, DCT/quantizer, bitstream writer).
//   Round-robin arbitration; the winner keeps the bus for a whole burst.
//   Address, write data and write enable toward the SRAM are registered.
//   Each read is tagged with its requester so the returning data-valid
//   pulse goes back to whoever issued it.
//
// Ports
//   Clock, Resetn      system clock, asynchronous active-low reset
//   req/req_we         per-requester request (held for the burst) / write strobe
//   req_addr/req_wdata flattened per-requester address / write data
//   gnt                registered one-hot grant
//   rvalid/rdata       one-cycle read-return pulse per requester, shared data
//   SRAM_address, SRAM_write_data, SRAM_we_n   registered SRAM controls
//   SRAM_read_data     data returned by the SRAM controller
//   busy               arbiter is not idle
//   stall_cnt          (only with SRAM_ARB_STALL_CNT_EN) 32-bit wait counter per requester
//
// Optional feature macro: SRAM_ARB_STALL_CNT_EN
//
// state | meaning
// IDLE  | no owner; pick the next requester at/after rr_ptr
// OWN   | one requester owns the bus; every cycle with its req high is an access
// DRAIN | owner released; wait for outstanding read tags to retire

module sram_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int READ_LAT  = 2,
    parameter int MAX_BURST = 0
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           SRAM_address,
    output logic [DATA_W-1:0]           SRAM_write_data,
    output logic                        SRAM_we_n,
    input  logic [DATA_W-1:0]           SRAM_read_data,
    output logic                        busy
`ifdef SRAM_ARB_STALL_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]       stall_cnt
`endif
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int DEPTH   = READ_LAT + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 2);
    localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_DRAIN} state_t;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [IDX_W-1:0]    own_idx, own_nxt;
    logic [IDX_W-1:0]    rr_ptr, rr_nxt;
    logic [BURST_W-1:0]  burst_left, burst_nxt;
    logic                access, force_rel, others_req;

    logic                own_req, own_we;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W:0]       pick_sum;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    logic [DEPTH-1:0]     pipe_vld;
    logic [IDX_W-1:0]     pipe_tag [DEPTH];

    // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
    assign req_dbl  = {req, req};
    assign req_rot  = NUM_REQ'(req_dbl >> rr_ptr);
    assign pick_vld = |req;

    always_comb begin
        pick_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) pick_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        end
        pick_idx = (pick_sum >= (IDX_W+1)'(NUM_REQ)) ?
                   IDX_W'(pick_sum - (IDX_W+1)'(NUM_REQ)) : pick_sum[IDX_W-1:0];
    end

    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own_idx == IDX_W'(i)) begin
                own_req   = req[i];
                own_we    = req_we[i];
                own_addr  = req_addr[i*ADDR_W +: ADDR_W];
                own_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign others_req = |(req & ~gnt);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        own_nxt   = own_idx;
        rr_nxt    = rr_ptr;
        burst_nxt = burst_left;
        access    = 1'b0;
        force_rel = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt   = REQ_ONE << pick_idx;
                    own_nxt   = pick_idx;
                    burst_nxt = BURST_W'(MAX_BURST);
                    state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                // burst_left counts down per access; zero with a rival waiting forces release
                force_rel = (MAX_BURST > 0) && (burst_left == '0) && others_req;
                if (!own_req || force_rel) begin
                    gnt_nxt   = '0;
                    rr_nxt    = (own_idx == IDX_W'(NUM_REQ - 1)) ? '0 : own_idx + 1'b1;
                    state_nxt = ST_DRAIN;
                end else begin
                    access = 1'b1;
                    if (burst_left != '0) burst_nxt = burst_left - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (pipe_vld == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            own_idx    <= '0;
            rr_ptr     <= '0;
            burst_left <= '0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            own_idx    <= own_nxt;
            rr_ptr     <= rr_nxt;
            burst_left <= burst_nxt;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
        end else if (access) begin
            SRAM_address    <= own_addr;
            SRAM_write_data <= own_wdata;
            SRAM_we_n       <= ~own_we;
        end else begin
            SRAM_we_n       <= 1'b1;
        end
    end

    // Tag stage k holds a read issued k+1 edges ago; the last stage lines up
    // with SRAM_read_data being valid, so it is captured on the next edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pipe_vld <= '0;
            for (int k = 0; k < DEPTH; k++) pipe_tag[k] <= '0;
            rvalid   <= '0;
            rdata    <= '0;
        end else begin
            pipe_vld[0] <= access & ~own_we;
            pipe_tag[0] <= own_idx;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_tag[k] <= pipe_tag[k-1];
            end
            rvalid <= pipe_vld[DEPTH-1] ? (REQ_ONE << pipe_tag[DEPTH-1]) : '0;
            if (pipe_vld[DEPTH-1]) rdata <= SRAM_read_data;
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef SRAM_ARB_STALL_CNT_EN
    // The arbitration edge that issues a grant is not a stall.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && !gnt[i] && !gnt_nxt[i] &&
                    stall_cnt[i*32 +: 32] != 32'hFFFF_FFFF)
                    stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter. dut_a uses the default (unlimited burst)
//   build, dut_b has MAX_BURST=8; both see the same requester stimulus and
//   each drives its own small SRAM model with a 2-cycle read latency.

module tb_sram_arbiter;

    localparam int NR = 4;
    localparam int AW = 18;
    localparam int DW = 16;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #10 Clock = ~Clock;

    logic [NR-1:0]    req, req_we;
    logic [AW-1:0]    a_arr [NR];
    logic [DW-1:0]    d_arr [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = a_arr[i];
            req_wdata[i*DW +: DW] = d_arr[i];
        end
    end

    logic [NR-1:0] gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [DW-1:0] rdata_a, wd_a, rd_a, rdata_b, wd_b, rd_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          we_n_a, busy_a, we_n_b, busy_b;
`ifdef SRAM_ARB_STALL_CNT_EN
    logic [NR*32-1:0] stall_a, stall_b;
`endif

    sram_arbiter dut_a (
        .Clock(Clock), .Resetn(Resetn), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_a), .rvalid(rvalid_a),
        .rdata(rdata_a), .SRAM_address(addr_a), .SRAM_write_data(wd_a),
        .SRAM_we_n(we_n_a), .SRAM_read_data(rd_a), .busy(busy_a)
`ifdef SRAM_ARB_STALL_CNT_EN
        , .stall_cnt(stall_a)
`endif
    );

    sram_arbiter #(.MAX_BURST(8)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_b), .rvalid(rvalid_b),
        .rdata(rdata_b), .SRAM_address(addr_b), .SRAM_write_data(wd_b),
        .SRAM_we_n(we_n_b), .SRAM_read_data(rd_b), .busy(busy_b)
`ifdef SRAM_ARB_STALL_CNT_EN
        , .stall_cnt(stall_b)
`endif
    );

    // SRAM models: data for the address driven at edge E is on read_data after E+2.
    logic          preload = 1'b0;
    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    logic [DW-1:0] s1_a, s2_a, s1_b, s2_b;

    always @(posedge Clock) begin
        if (preload) begin
            mem_a[18'd0] <= 16'hA000; mem_a[18'd1] <= 16'hA001;
            mem_a[18'd2] <= 16'hA002; mem_a[18'd3] <= 16'hA003;
        end else if (!we_n_a) begin
            mem_a[addr_a] <= wd_a;
        end
        s1_a <= mem_a[addr_a];
        s2_a <= s1_a;
    end

    always @(posedge Clock) begin
        if (preload) begin
            mem_b[18'd0] <= 16'hA000; mem_b[18'd1] <= 16'hA001;
            mem_b[18'd2] <= 16'hA002; mem_b[18'd3] <= 16'hA003;
        end else if (!we_n_b) begin
            mem_b[addr_b] <= wd_b;
        end
        s1_b <= mem_b[addr_b];
        s2_b <= s1_b;
    end

    assign rd_a = s2_a;
    assign rd_b = s2_b;

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        req = '0; req_we = '0;
        for (int i = 0; i < NR; i++) begin a_arr[i] = '0; d_arr[i] = '0; end
        Resetn = 1'b0; preload = 1'b1;
        step();
        preload = 1'b0;
        step();
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
        checks++; if (rvalid_a !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b want 0000", rvalid_a); end
        checks++; if (rdata_a !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata_a); end
        checks++; if (addr_a !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_a); end
        checks++; if (wd_a !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h want 0000", wd_a); end
        checks++; if (we_n_a !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b want 1", we_n_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (gnt_b !== 4'b0000 || we_n_b !== 1'b1) begin errors++; $display("FAIL reset_b: gnt %b we_n %b want 0000 1", gnt_b, we_n_b); end
        Resetn = 1'b1;
        step();
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_g;
        logic          exp_we;
        logic [1:0]    j;
        req_we = 4'b1111;
        a_arr[0] = 18'd100; a_arr[1] = 18'd101; a_arr[2] = 18'd102; a_arr[3] = 18'd103;
        d_arr[0] = 16'h5000; d_arr[1] = 16'h5001; d_arr[2] = 16'h5002; d_arr[3] = 16'h5003;
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            exp_g  = ((k % 5) <= 2) ? (4'b0001 << (k / 5)) : 4'b0000;
            exp_we = ((k % 5) == 1 || (k % 5) == 2) ? 1'b0 : 1'b1;
            checks++; if (gnt_a !== exp_g) begin errors++; $display("FAIL contention_gnt cyc %0d: got %b want %b", k, gnt_a, exp_g); end
            checks++; if (we_n_a !== exp_we) begin errors++; $display("FAIL contention_we_n cyc %0d: got %b want %b", k, we_n_a, exp_we); end
            if ((k % 5) == 2) begin j = 2'(k / 5); req[j] = 1'b0; end
        end
    endtask

    task automatic test_single_read();
        logic [NR-1:0] exp_rv;
        req_we = 4'b0000;
        a_arr[0] = 18'd0;
        req[0] = 1'b1;
        step();
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL read_grant: got %b want 0001", gnt_a); end
        for (int c = 1; c <= 9; c++) begin
            if (c <= 4) a_arr[0] = 18'(c - 1);
            else req[0] = 1'b0;
            step();
            exp_rv = (c >= 4 && c <= 7) ? 4'b0001 : 4'b0000;
            checks++; if (rvalid_a !== exp_rv) begin errors++; $display("FAIL read_rvalid cyc %0d: got %b want %b", c, rvalid_a, exp_rv); end
            if (c >= 4 && c <= 7) begin
                checks++; if (rdata_a !== 16'hA000 + 16'(c - 4)) begin errors++; $display("FAIL read_rdata cyc %0d: got %h want %h", c, rdata_a, 16'hA000 + 16'(c - 4)); end
            end
            if (c <= 4) begin
                checks++; if (addr_a !== 18'(c - 1)) begin errors++; $display("FAIL read_addr cyc %0d: got %0d want %0d", c, addr_a, c - 1); end
            end
            checks++; if (gnt_a !== ((c <= 4) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL read_gnt cyc %0d: got %b", c, gnt_a); end
            checks++; if (we_n_a !== 1'b1) begin errors++; $display("FAIL read_we_n cyc %0d: got %b want 1", c, we_n_a); end
            checks++; if (busy_a !== (c <= 7)) begin errors++; $display("FAIL read_busy cyc %0d: got %b want %b", c, busy_a, (c <= 7)); end
        end
    endtask

    task automatic test_write();
        a_arr[2] = 18'h16000;
        d_arr[2] = 16'h1234;
        req_we[2] = 1'b1;
        req[2] = 1'b1;
        step();
        checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL write_grant: got %b want 0100", gnt_a); end
        checks++; if (we_n_a !== 1'b1) begin errors++; $display("FAIL write_we_n_pre: got %b want 1", we_n_a); end
        step();
        checks++; if (we_n_a !== 1'b0) begin errors++; $display("FAIL write_we_n: got %b want 0", we_n_a); end
        checks++; if (addr_a !== 18'h16000) begin errors++; $display("FAIL write_addr: got %h want 16000", addr_a); end
        checks++; if (wd_a !== 16'h1234) begin errors++; $display("FAIL write_data: got %h want 1234", wd_a); end
        req[2] = 1'b0;
        step();
        checks++; if (we_n_a !== 1'b1) begin errors++; $display("FAIL write_we_n_post: got %b want 1", we_n_a); end
        checks++; if (gnt_a !== 4'b0000 || busy_a !== 1'b1) begin errors++; $display("FAIL write_release: gnt %b busy %b want 0000 1", gnt_a, busy_a); end
        checks++; if (mem_a[18'h16000] !== 16'h1234) begin errors++; $display("FAIL write_mem: got %h want 1234", mem_a[18'h16000]); end
        step();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL write_drain_len: busy %b want 0", busy_a); end
    endtask

    task automatic test_max_burst();
        req_we[1] = 1'b1; req_we[3] = 1'b1;
        a_arr[1] = 18'd200; d_arr[1] = 16'h2001;
        a_arr[3] = 18'd203; d_arr[3] = 16'h2003;
        req[1] = 1'b1;
        step();
        checks++; if (gnt_b !== 4'b0010) begin errors++; $display("FAIL burst_grant1: got %b want 0010", gnt_b); end
        req[3] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            checks++; if (gnt_b !== 4'b0010 || we_n_b !== 1'b0) begin errors++; $display("FAIL burst_access %0d: gnt %b we_n %b want 0010 0", n, gnt_b, we_n_b); end
        end
        step();
        checks++; if (gnt_b !== 4'b0000 || we_n_b !== 1'b1) begin errors++; $display("FAIL burst_force: gnt %b we_n %b want 0000 1", gnt_b, we_n_b); end
        checks++; if (gnt_a !== 4'b0010 || we_n_a !== 1'b0) begin errors++; $display("FAIL burst_unlimited: gnt %b we_n %b want 0010 0", gnt_a, we_n_a); end
        step();
        step();
        checks++; if (gnt_b !== 4'b1000) begin errors++; $display("FAIL burst_grant3: got %b want 1000", gnt_b); end
        req[3] = 1'b0;
        step();
        step();
        step();
        checks++; if (gnt_b !== 4'b0010) begin errors++; $display("FAIL burst_regrant1: got %b want 0010", gnt_b); end
        checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL burst_unlimited_hold: got %b want 0010", gnt_a); end
        for (int n = 1; n <= 10; n++) begin
            step();
            checks++; if (gnt_b !== 4'b0010 || we_n_b !== 1'b0) begin errors++; $display("FAIL burst_lone %0d: gnt %b we_n %b want 0010 0", n, gnt_b, we_n_b); end
        end
        req[1] = 1'b0;
        step();
        checks++; if (gnt_a !== 4'b0000 || gnt_b !== 4'b0000) begin errors++; $display("FAIL burst_release: gnt_a %b gnt_b %b want 0000", gnt_a, gnt_b); end
        step();
        step();
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL burst_idle: busy_a %b busy_b %b want 0", busy_a, busy_b); end
    endtask

    task automatic test_reset_mid_read();
        req_we = 4'b0000;
        a_arr[0] = 18'd1;
        req[0] = 1'b1;
        step();
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL rst_pre_grant: got %b want 0001", gnt_a); end
        step();
        req[0] = 1'b0;
        step();
        step();
        Resetn = 1'b0;
        #1;
        checks++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_async_ctl: gnt %b busy %b want 0000 0", gnt_a, busy_a); end
        checks++; if (addr_a !== 18'h0 || we_n_a !== 1'b1) begin errors++; $display("FAIL rst_async_sram: addr %h we_n %b want 0 1", addr_a, we_n_a); end
        checks++; if (rdata_a !== 16'h0000 || rvalid_a !== 4'b0000) begin errors++; $display("FAIL rst_async_rd: rdata %h rvalid %b want 0000 0000", rdata_a, rvalid_a); end
        checks++; if (wd_a !== 16'h0000) begin errors++; $display("FAIL rst_async_wdata: got %h want 0000", wd_a); end
        step();
        step();
        Resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (rvalid_a !== 4'b0000) begin errors++; $display("FAIL rst_no_rvalid cyc %0d: got %b want 0000", c, rvalid_a); end
        end
        a_arr[2] = 18'd2;
        req_we[2] = 1'b0;
        req[2] = 1'b1;
        step();
        checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL rst_fresh_grant: got %b want 0100", gnt_a); end
        step();
        req[2] = 1'b0;
        step();
        step();
        step();
        checks++; if (rvalid_a !== 4'b0100) begin errors++; $display("FAIL rst_fresh_rvalid: got %b want 0100", rvalid_a); end
        checks++; if (rdata_a !== 16'hA002) begin errors++; $display("FAIL rst_fresh_rdata: got %h want a002", rdata_a); end
        step();
        checks++; if (busy_a !== 1'b0 || rvalid_a !== 4'b0000) begin errors++; $display("FAIL rst_fresh_idle: busy %b rvalid %b want 0 0000", busy_a, rvalid_a); end
    endtask

`ifdef SRAM_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        req_we = 4'b0011;
        a_arr[0] = 18'd300; a_arr[1] = 18'd301;
        req[1:0] = 2'b11;
        step();
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL stall_grant0: got %b want 0001", gnt_a); end
        for (int n = 1; n <= 7; n++) step();
        req[0] = 1'b0;
        step();
        step();
        step();
        checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL stall_grant1: got %b want 0010", gnt_a); end
        checks++; if (stall_a[63:32] !== 32'd10) begin errors++; $display("FAIL stall_cnt1: got %0d want 10", stall_a[63:32]); end
        checks++; if (stall_a[31:0] !== 32'd0) begin errors++; $display("FAIL stall_cnt0: got %0d want 0", stall_a[31:0]); end
        req[1] = 1'b0;
        step();
        step();
        step();
        checks++; if (stall_a[63:32] !== 32'd10) begin errors++; $display("FAIL stall_cnt1_hold: got %0d want 10", stall_a[63:32]); end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_write();
        test_max_burst();
        test_reset_mid_read();
`ifdef SRAM_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
